mfunc_apb_reg_bridge: RTL and testbench
=======================================

// Module: mfunc_apb_reg_bridge
// PURPOSE
//   APB3 slave front end for the MFUNC register sub-blocks. Decodes each APB
//   transfer into a one-cycle write strobe or a read select for one sub-block.
//   Drives the shared 12-bit sub-register address and 32-bit write data.
//   Captures the selected sub-block's combinational read data and returns it
//   with a fixed three-cycle response; flags unmapped or misaligned accesses.
// PARAMETERS
//   NUM_SUB   4   number of attached sub-blocks, 1..16; sub index = paddr[15:12]
// PORTS
//   clk            in   1            system clock; all state on rising edge
//   rst_n          in   1            asynchronous active-low reset
//   psel           in   1            APB select
//   penable        in   1            APB enable (access phase)
//   pwrite         in   1            1 = write, 0 = read
//   paddr          in   16           byte address: [15:12] sub index, [11:0] sub address
//   pwdata         in   32           APB write data
//   prdata         out  32           APB read data, valid while pready=1
//   pready         out  1            transfer complete
//   pslverr        out  1            error response, valid while pready=1
//   sub_wr_en      out  NUM_SUB      one-hot write strobe, bit i -> sub-block i
//   sub_reg_addr   out  12           shared sub-register address
//   reg_wr_data    out  32           shared write data
//   sub_rd_data    in   NUM_SUB*32   read data; sub-block i on bits [32i+31:32i]
// BEHAVIOUR
//   Reset: state=IDLE; prdata, pready, pslverr, sub_wr_en, sub_reg_addr,
//     reg_wr_data all 0. An asserted reset aborts any transfer. No strobe is
//     issued during reset or on the first cycle after release.
//   FSM: IDLE -> ACCESS -> RESP -> IDLE, one cycle per state.
//   IDLE: on psel=1 & penable=0, register paddr[11:0] into sub_reg_addr and
//     pwdata into reg_wr_data. Latch pwrite, the sub index, and
//     err = (paddr[15:12] >= NUM_SUB) | (paddr[1:0] != 0). Go to ACCESS.
//     All other IDLE inputs are ignored.
//   ACCESS: pready=0.
//     Write with !err: sub_wr_en[idx]=1 for exactly this cycle; all other bits 0.
//     Read with !err: register sub_rd_data[idx] into a read holding register.
//     err: no strobe; read holding register loads 0.
//     If psel=0 in ACCESS (protocol abort): go to IDLE, no RESP. A write strobe
//     already issued in this cycle stands.
//   RESP: pready=1, prdata=holding register (0 for writes), pslverr=err.
//     Next state is IDLE unconditionally. prdata/pslverr return to 0 in IDLE.
//   Latency: setup cycle N, ACCESS N+1, pready=1 in cycle N+2.
//     Back-to-back: the next setup is accepted in the first IDLE cycle after RESP.
//   sub_reg_addr and reg_wr_data hold their last latched value between transfers.
//   sub_wr_en is never more than one-hot and never high outside ACCESS.
//   Reads have no side effects. The bridge performs no byte-strobe handling:
//     all writes are full 32-bit.
// TESTING
//   1. NUM_SUB=4; write paddr=0x2004, pwdata=0x1234_5678 -> sub_wr_en=4'b0100
//      for exactly the ACCESS cycle, sub_reg_addr=0x004, reg_wr_data=0x12345678;
//      pready=1 and pslverr=0 two cycles after setup.
//   2. Read paddr=0x2008, sub-block 2 stub returns 0x0000_0002 -> prdata=0x2,
//      pslverr=0 in RESP; sub_wr_en stays 0 throughout.
//   3. Write paddr=0x5000 (idx 5 >= NUM_SUB) -> no strobe, pslverr=1, prdata=0;
//      read paddr=0x1006 (misaligned) -> pslverr=1, prdata=0.
//   4. Back-to-back: write 0x0000=0x1 then read 0x0000 with setup in the cycle
//      after RESP -> both complete in 3 cycles each; read returns the stub value
//      written (0x1).
//   5. Assert rst_n low during ACCESS of a read -> pready, prdata, sub_wr_en go
//      to 0 immediately; after release the FSM is in IDLE and no RESP is issued.
//   6. Drop psel in ACCESS of a write to 0x3000 -> strobe seen once, FSM returns
//      to IDLE, pready never asserted for that transfer.

Source files
------------

// File: rtl/mfunc_apb_reg_bridge.sv
// APB3 slave bridge for the MFUNC register sub-blocks: decodes transfers into
// one-hot write strobes or read selects and answers with a fixed 3-cycle response.
module mfunc_apb_reg_bridge #(
  parameter int NUM_SUB = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [15:0]            paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic [NUM_SUB-1:0]     sub_wr_en,
  output logic [11:0]            sub_reg_addr,
  output logic [31:0]            reg_wr_data,
  input  logic [NUM_SUB*32-1:0]  sub_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic        r_err;
  logic [3:0]  r_idx;
  logic [31:0] r_rdata;
  logic [31:0] w_sel;
  logic        w_setup;
  logic        w_err;

  assign w_setup = (r_state == IDLE) & psel & ~penable;
  // Out-of-range sub index or non-word-aligned address is answered with an error.
  assign w_err   = ({28'd0, paddr[15:12]} >= 32'(NUM_SUB)) | (paddr[1:0] != 2'b00);

  always_comb begin
    w_sel = 32'd0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (r_idx == 4'(i)) w_sel = sub_rd_data[i*32 +: 32];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next = ACCESS;
      ACCESS:  w_next = psel ? RESP : IDLE;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    sub_wr_en = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'd0;
    if (r_state == ACCESS && r_wr && !r_err) begin
      for (int i = 0; i < NUM_SUB; i++) begin
        if (r_idx == 4'(i)) sub_wr_en[i] = 1'b1;
      end
    end
    if (r_state == RESP) begin
      pready  = 1'b1;
      pslverr = r_err;
      prdata  = r_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr         <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= 4'd0;
      r_rdata      <= 32'd0;
      sub_reg_addr <= 12'd0;
      reg_wr_data  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_setup) begin
        sub_reg_addr <= paddr[11:0];
        reg_wr_data  <= pwdata;
        r_wr         <= pwrite;
        r_idx        <= paddr[15:12];
        r_err        <= w_err;
      end
      // Writes and errored accesses return zero read data.
      if (r_state == ACCESS) r_rdata <= (r_err | r_wr) ? 32'd0 : w_sel;
    end
  end

endmodule

// File: tb/tb_mfunc_apb_reg_bridge.sv
// Directed bench for mfunc_apb_reg_bridge with a small per-sub-block register stub.
module tb_mfunc_apb_reg_bridge;
  localparam int NUM_SUB = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  psel = 1'b0;
  logic                  penable = 1'b0;
  logic                  pwrite = 1'b0;
  logic [15:0]           paddr = 16'd0;
  logic [31:0]           pwdata = 32'd0;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;
  logic [NUM_SUB-1:0]    sub_wr_en;
  logic [11:0]           sub_reg_addr;
  logic [31:0]           reg_wr_data;
  logic [NUM_SUB*32-1:0] sub_rd_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] stub_mem [NUM_SUB][4];

  mfunc_apb_reg_bridge #(.NUM_SUB(NUM_SUB)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .sub_wr_en(sub_wr_en), .sub_reg_addr(sub_reg_addr),
    .reg_wr_data(reg_wr_data), .sub_rd_data(sub_rd_data)
  );

  always #5 clk = ~clk;

  // Stub word j of sub-block i resets to i and captures strobed writes.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SUB; i++)
        for (int j = 0; j < 4; j++) stub_mem[i][j] <= 32'(i);
    end else begin
      for (int i = 0; i < NUM_SUB; i++)
        if (sub_wr_en[i]) stub_mem[i][sub_reg_addr[3:2]] <= reg_wr_data;
    end
  end

  always_comb begin
    sub_rd_data = '0;
    for (int i = 0; i < NUM_SUB; i++) sub_rd_data[i*32 +: 32] = stub_mem[i][sub_reg_addr[3:2]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one full transfer starting just after a rising edge and returns what was seen.
  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                          output logic [NUM_SUB-1:0] wen_acc, output logic rdy_acc,
                          output logic [11:0] addr_acc, output logic [31:0] wdata_acc,
                          output logic rdy_resp, output logic [31:0] rdata_resp,
                          output logic err_resp, output logic [NUM_SUB-1:0] wen_resp);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    wen_acc = sub_wr_en; rdy_acc = pready; addr_acc = sub_reg_addr; wdata_acc = reg_wr_data;
    @(posedge clk);
    @(negedge clk);
    rdy_resp = pready; rdata_resp = prdata; err_resp = pslverr; wen_resp = sub_wr_en;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [NUM_SUB-1:0] o_wen_a, o_wen_r;
  logic               o_rdy_a, o_rdy_r, o_err;
  logic [11:0]        o_addr;
  logic [31:0]        o_wdata, o_rdata;

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (pready !== 1'b0) begin tests_failed++; $display("FAIL reset_pready got %0b want 0", pready); end
    tests_run++; if (prdata !== 32'd0 || pslverr !== 1'b0) begin tests_failed++; $display("FAIL reset_prdata got %h/%0b want 0/0", prdata, pslverr); end
    tests_run++; if (sub_wr_en !== 4'd0 || sub_reg_addr !== 12'd0 || reg_wr_data !== 32'd0) begin tests_failed++; $display("FAIL reset_outs got %b %h %h want 0 0 0", sub_wr_en, sub_reg_addr, reg_wr_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (sub_wr_en !== 4'd0 || pready !== 1'b0) begin tests_failed++; $display("FAIL post_reset got wen=%b rdy=%0b want 0 0", sub_wr_en, pready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    apb_xfer(1'b1, 16'h2004, 32'h1234_5678, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_wen_a !== 4'b0100) begin tests_failed++; $display("FAIL wr_strobe got %b want 0100", o_wen_a); end
    tests_run++; if (o_addr !== 12'h004 || o_wdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL wr_addr_data got %h %h want 004 12345678", o_addr, o_wdata); end
    tests_run++; if (o_rdy_a !== 1'b0) begin tests_failed++; $display("FAIL wr_access_pready got %0b want 0", o_rdy_a); end
    tests_run++; if (o_rdy_r !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'd0) begin tests_failed++; $display("FAIL wr_resp got rdy=%0b err=%0b rd=%h want 1 0 0", o_rdy_r, o_err, o_rdata); end
    tests_run++; if (o_wen_r !== 4'd0) begin tests_failed++; $display("FAIL wr_strobe_resp got %b want 0000", o_wen_r); end
    @(negedge clk);
    tests_run++; if (pready !== 1'b0 || sub_reg_addr !== 12'h004 || reg_wr_data !== 32'h1234_5678) begin tests_failed++; $display("FAIL wr_idle_hold got rdy=%0b %h %h want 0 004 12345678", pready, sub_reg_addr, reg_wr_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    apb_xfer(1'b0, 16'h2008, 32'hDEAD_BEEF, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_wen_a !== 4'd0 || o_wen_r !== 4'd0) begin tests_failed++; $display("FAIL rd_no_strobe got %b %b want 0000 0000", o_wen_a, o_wen_r); end
    tests_run++; if (o_rdy_r !== 1'b1 || o_rdata !== 32'h0000_0002 || o_err !== 1'b0) begin tests_failed++; $display("FAIL rd_resp got rdy=%0b rd=%h err=%0b want 1 00000002 0", o_rdy_r, o_rdata, o_err); end
    @(negedge clk);
    tests_run++; if (prdata !== 32'd0) begin tests_failed++; $display("FAIL rd_idle_prdata got %h want 0", prdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors;
    apb_xfer(1'b1, 16'h5000, 32'hFFFF_FFFF, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_wen_a !== 4'd0) begin tests_failed++; $display("FAIL err_wr_strobe got %b want 0000", o_wen_a); end
    tests_run++; if (o_rdy_r !== 1'b1 || o_err !== 1'b1 || o_rdata !== 32'd0) begin tests_failed++; $display("FAIL err_wr_resp got rdy=%0b err=%0b rd=%h want 1 1 0", o_rdy_r, o_err, o_rdata); end
    @(negedge clk);
    tests_run++; if (pslverr !== 1'b0) begin tests_failed++; $display("FAIL err_idle_pslverr got %0b want 0", pslverr); end
    @(posedge clk); #1;
    apb_xfer(1'b0, 16'h1006, 32'd0, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_rdy_r !== 1'b1 || o_err !== 1'b1 || o_rdata !== 32'd0) begin tests_failed++; $display("FAIL err_misalign_resp got rdy=%0b err=%0b rd=%h want 1 1 0", o_rdy_r, o_err, o_rdata); end
  endtask

  task automatic test_back_to_back;
    apb_xfer(1'b1, 16'h0000, 32'h0000_0001, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_wen_a !== 4'b0001 || o_rdy_r !== 1'b1 || o_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_wr got wen=%b rdy=%0b err=%0b want 0001 1 0", o_wen_a, o_rdy_r, o_err); end
    apb_xfer(1'b0, 16'h0000, 32'd0, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_rdy_a !== 1'b0 || o_rdy_r !== 1'b1 || o_rdata !== 32'h0000_0001) begin tests_failed++; $display("FAIL b2b_rd got rdy_a=%0b rdy_r=%0b rd=%h want 0 1 00000001", o_rdy_a, o_rdy_r, o_rdata); end
  endtask

  task automatic test_reset_abort;
    logic seen_rdy;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h1008; pwdata = 32'd0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    tests_run++; if (sub_reg_addr !== 12'h008) begin tests_failed++; $display("FAIL rst_abort_setup got %h want 008", sub_reg_addr); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (pready !== 1'b0 || prdata !== 32'd0 || sub_wr_en !== 4'd0 || sub_reg_addr !== 12'd0) begin tests_failed++; $display("FAIL rst_abort_async got rdy=%0b rd=%h wen=%b addr=%h want 0 0 0 0", pready, prdata, sub_wr_en, sub_reg_addr); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    seen_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready !== 1'b0) seen_rdy = 1'b1;
    end
    tests_run++; if (seen_rdy !== 1'b0) begin tests_failed++; $display("FAIL rst_abort_no_resp got pready seen=%0b want 0", seen_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_psel_abort;
    logic seen_rdy;
    logic [1:0] strobes;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h3000; pwdata = 32'hA5A5_0033;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen_rdy = 1'b0; strobes = 2'd0;
    repeat (4) begin
      @(negedge clk);
      if (pready !== 1'b0) seen_rdy = 1'b1;
      if (sub_wr_en == 4'b1000) strobes = strobes + 2'd1;
      else if (sub_wr_en !== 4'd0) strobes = 2'd3;
    end
    tests_run++; if (strobes !== 2'd1) begin tests_failed++; $display("FAIL psel_abort_strobe got %0d strobes want 1", strobes); end
    tests_run++; if (seen_rdy !== 1'b0) begin tests_failed++; $display("FAIL psel_abort_no_resp got pready seen=%0b want 0", seen_rdy); end
    @(posedge clk); #1;
    apb_xfer(1'b0, 16'h3000, 32'd0, o_wen_a, o_rdy_a, o_addr, o_wdata, o_rdy_r, o_rdata, o_err, o_wen_r);
    tests_run++; if (o_rdy_r !== 1'b1 || o_rdata !== 32'hA5A5_0033) begin tests_failed++; $display("FAIL psel_abort_readback got rdy=%0b rd=%h want 1 a5a50033", o_rdy_r, o_rdata); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_psel_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
